// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_AUX = 1'b1;

  // Lock-owner state for a given port.
  function automatic arb_state_t own_state(input port_id_t p);
    return (p == PORT_AUX) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/ram_arb_sat_counter.sv
// 16-bit saturating event counter with synchronous clear and count enable.
module ram_arb_sat_counter (
  input  logic        i_clk,
  input  logic        i_rstN,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  // Count up on enable, hold at all-ones, clear takes priority.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN)
      r_count <= '0;
    else if (i_clr)
      r_count <= '0;
    else if (i_en && (r_count != '1))
      r_count <= r_count + 16'd1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port (CPU / AUX) arbiter in front of a 1W/1R synchronous RAM.
// One access per cycle, round-robin ties, bounded bus lock, range check.
// Optional statistics counters enabled by defining RAM_ARB_STATS_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned NumRegs   = 4096,
  parameter int unsigned MaxLock   = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [1:0]           lock,
  input  logic [AddrWidth-1:0] addr0,
  input  logic [AddrWidth-1:0] addr1,
  input  logic [DataWidth-1:0] wdata0,
  input  logic [DataWidth-1:0] wdata1,
  output logic [1:0]           gnt,
  output logic [1:0]           rvalid,
  output logic [DataWidth-1:0] rdata,
  output logic [1:0]           err,
  output logic                 ramWriteEnable,
  output logic [AddrWidth-1:0] ramWriteAddr,
  output logic [DataWidth-1:0] ramWriteData,
  output logic [AddrWidth-1:0] ramReadAddr,
  input  logic [DataWidth-1:0] ramReadData
`ifdef RAM_ARB_STATS_EN
  ,
  input  logic                 statsClr,
  output logic [15:0]          grantCnt0,
  output logic [15:0]          grantCnt1,
  output logic [15:0]          conflictCnt
`endif
);

  localparam int unsigned   CntW       = $clog2(MaxLock + 1);
  localparam logic [CntW-1:0] MAX_LOCK_C = CntW'(MaxLock);
  localparam logic [63:0]   NUM_REGS_C = 64'(NumRegs);

  arb_state_t      r_state, w_stateNext;
  logic [CntW-1:0] r_lockCnt, w_lockCntNext;
  port_id_t        r_lastGnt;
  logic [1:0]      r_rvalid, r_err;
  logic            r_rdZero;

  logic            w_gntValid;
  port_id_t        w_gntPort;
  port_id_t        w_owner, w_idlePort;
  logic [1:0]      w_gnt;
  logic [AddrWidth-1:0] w_addr;
  logic [DataWidth-1:0] w_wdata;
  logic            w_we, w_inRange;

  assign w_owner    = (r_state == OWN1) ? PORT_AUX : PORT_CPU;
  assign w_idlePort = (&req) ? ~r_lastGnt : req[1];

  // Grant selection, lock ownership and lock-bound counting.
  always_comb begin
    w_stateNext   = r_state;
    w_lockCntNext = r_lockCnt;
    w_gntValid    = 1'b0;
    w_gntPort     = PORT_CPU;
    if ((r_state != IDLE) && req[w_owner] && lock[w_owner]) begin
      if (req[~w_owner] && (r_lockCnt >= MAX_LOCK_C)) begin
        w_gntValid    = 1'b1;
        w_gntPort     = ~w_owner;
        w_stateNext   = lock[~w_owner] ? own_state(~w_owner) : IDLE;
        w_lockCntNext = '0;
      end else begin
        w_gntValid    = 1'b1;
        w_gntPort     = w_owner;
        w_lockCntNext = req[~w_owner] ? r_lockCnt + CntW'(1) : '0;
      end
    end else if (|req) begin
      // Entry grant into a lock already counts toward the bound.
      w_gntValid    = 1'b1;
      w_gntPort     = w_idlePort;
      w_stateNext   = lock[w_idlePort] ? own_state(w_idlePort) : IDLE;
      w_lockCntNext = (lock[w_idlePort] && req[~w_idlePort]) ? CntW'(1) : '0;
    end else begin
      w_stateNext   = IDLE;
      w_lockCntNext = '0;
    end
  end

  // Datapath mux from the granted port and range check.
  always_comb begin
    w_gnt     = '0;
    w_addr    = '0;
    w_wdata   = '0;
    w_we      = 1'b0;
    if (w_gntValid) begin
      w_gnt   = (w_gntPort == PORT_AUX) ? 2'b10 : 2'b01;
      w_addr  = (w_gntPort == PORT_AUX) ? addr1 : addr0;
      w_wdata = (w_gntPort == PORT_AUX) ? wdata1 : wdata0;
      w_we    = we[w_gntPort];
    end
    w_inRange = (64'(w_addr) < NUM_REGS_C);
  end

  // Arbiter state, lock counter and round-robin history.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= IDLE;
      r_lockCnt <= '0;
      r_lastGnt <= PORT_AUX;
    end else begin
      r_state   <= w_stateNext;
      r_lockCnt <= w_lockCntNext;
      if (w_gntValid)
        r_lastGnt <= w_gntPort;
    end
  end

  // Read-valid / error pulses one cycle after acceptance.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdZero <= 1'b0;
    end else begin
      r_rvalid <= (w_gntValid && !w_we) ? w_gnt : 2'b00;
      r_err    <= (w_gntValid && !w_inRange) ? w_gnt : 2'b00;
      r_rdZero <= w_gntValid && !w_we && !w_inRange;
    end
  end

  assign gnt            = w_gnt;
  assign rvalid         = r_rvalid;
  assign err            = r_err;
  assign rdata          = r_rdZero ? '0 : ramReadData;
  assign ramWriteEnable = w_gntValid & w_we & w_inRange;
  assign ramWriteAddr   = w_addr;
  assign ramWriteData   = w_wdata;
  assign ramReadAddr    = w_addr;

`ifdef RAM_ARB_STATS_EN
  ram_arb_sat_counter u_grant_cnt0 (
    .i_clk(clk), .i_rstN(rstN), .i_clr(statsClr), .i_en(w_gnt[0]), .o_count(grantCnt0)
  );
  ram_arb_sat_counter u_grant_cnt1 (
    .i_clk(clk), .i_rstN(rstN), .i_clr(statsClr), .i_en(w_gnt[1]), .o_count(grantCnt1)
  );
  ram_arb_sat_counter u_conflict_cnt (
    .i_clk(clk), .i_rstN(rstN), .i_clr(statsClr), .i_en(&req), .o_count(conflictCnt)
  );
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 4096x16 sync RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  req, we, lock;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, rvalid, err;
  logic [15:0] rdata;
  logic        ramWriteEnable;
  logic [15:0] ramWriteAddr, ramWriteData, ramReadAddr;
  logic [15:0] ramReadData;
`ifdef RAM_ARB_STATS_EN
  logic        statsClr = 1'b0;
  logic [15:0] grantCnt0, grantCnt1, conflictCnt;
`endif

  logic [15:0] mem [0:4095];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .DataWidth(16), .AddrWidth(16), .NumRegs(4096), .MaxLock(8)
  ) dut (
    .clk(clk), .rstN(rstN), .req(req), .we(we), .lock(lock),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .ramWriteEnable(ramWriteEnable), .ramWriteAddr(ramWriteAddr),
    .ramWriteData(ramWriteData), .ramReadAddr(ramReadAddr),
    .ramReadData(ramReadData)
`ifdef RAM_ARB_STATS_EN
    , .statsClr(statsClr), .grantCnt0(grantCnt0), .grantCnt1(grantCnt1),
    .conflictCnt(conflictCnt)
`endif
  );

  // RAM model: synchronous write, 1-cycle read latency.
  always @(posedge clk) begin
    if (ramWriteEnable) mem[ramWriteAddr[11:0]] <= ramWriteData;
    ramReadData <= mem[ramReadAddr[11:0]];
  end

  typedef struct {
    logic [1:0]  req, we, lock;
    logic [15:0] a0, a1, d0, d1;
    logic [1:0]  gnt;
    logic        rwe;
    logic [15:0] addr, wdata;
    logic [1:0]  rvalid, err;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(
    input logic [1:0] rq, input logic [1:0] w, input logic [1:0] lk,
    input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] d0, input logic [15:0] d1,
    input logic [1:0] g, input logic rwe, input logic [15:0] ad, input logic [15:0] wd,
    input logic [1:0] rv, input logic [1:0] er, input logic [15:0] rd);
    vec_t v;
    v.req = rq; v.we = w; v.lock = lk; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.gnt = g; v.rwe = rwe; v.addr = ad; v.wdata = wd; v.rvalid = rv; v.err = er; v.rdata = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] w, input logic [1:0] lk,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1);
    req = rq; we = w; lock = lk; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h000] = 16'h9999;
    mem[12'h010] = 16'hBEEF;
    mem[12'h020] = 16'h1111;
    mem[12'h030] = 16'h2222;
    mem[12'hFFF] = 16'h7777;

    //            req    we     lock   a0       a1       d0       d1       gnt    rwe  addr     wdata    rvalid err    rdata
    vecs[0]  = mk(2'b01, 2'b00, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0010, 16'h0000, 2'b00, 2'b00, 16'h0000);
    vecs[1]  = mk(2'b11, 2'b00, 2'b00, 16'h0020, 16'h0030, 16'h0000, 16'h0000, 2'b10, 1'b0, 16'h0030, 16'h0000, 2'b01, 2'b00, 16'hBEEF);
    vecs[2]  = mk(2'b11, 2'b00, 2'b00, 16'h0020, 16'h0030, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0020, 16'h0000, 2'b10, 2'b00, 16'h2222);
    vecs[3]  = mk(2'b11, 2'b00, 2'b00, 16'h0020, 16'h0030, 16'h0000, 16'h0000, 2'b10, 1'b0, 16'h0030, 16'h0000, 2'b01, 2'b00, 16'h1111);
    vecs[4]  = mk(2'b10, 2'b10, 2'b00, 16'h0000, 16'h0005, 16'h0000, 16'h00AA, 2'b10, 1'b1, 16'h0005, 16'h00AA, 2'b10, 2'b00, 16'h2222);
    vecs[5]  = mk(2'b01, 2'b00, 2'b00, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0005, 16'h0000, 2'b00, 2'b00, 16'h0000);
    vecs[6]  = mk(2'b01, 2'b01, 2'b00, 16'h1000, 16'h0000, 16'h1234, 16'h0000, 2'b01, 1'b0, 16'h1000, 16'h1234, 2'b01, 2'b00, 16'h00AA);
    vecs[7]  = mk(2'b01, 2'b00, 2'b00, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h1000, 16'h0000, 2'b00, 2'b01, 16'h0000);
    vecs[8]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 16'h0000, 2'b01, 2'b01, 16'h0000);
    vecs[9]  = mk(2'b01, 2'b00, 2'b00, 16'h0FFF, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0FFF, 16'h0000, 2'b00, 2'b00, 16'h0000);
    vecs[10] = mk(2'b10, 2'b10, 2'b00, 16'h0000, 16'hFFFF, 16'h0000, 16'hDEAD, 2'b10, 1'b0, 16'hFFFF, 16'hDEAD, 2'b01, 2'b00, 16'h7777);
    vecs[11] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 16'h0000, 2'b00, 2'b10, 16'h0000);
    vecs[12] = mk(2'b10, 2'b10, 2'b00, 16'h0000, 16'h0FFF, 16'h0000, 16'h4321, 2'b10, 1'b1, 16'h0FFF, 16'h4321, 2'b00, 2'b00, 16'h0000);
    vecs[13] = mk(2'b01, 2'b00, 2'b00, 16'h0FFF, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0FFF, 16'h0000, 2'b00, 2'b00, 16'h0000);
    vecs[14] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 16'h0000, 2'b01, 2'b00, 16'h4321);

    // Reset state
    rstN = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    #2;
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset rvalid", 32'(rvalid), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset ramWriteEnable", 32'(ramWriteEnable), 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].we, vecs[i].lock, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      #2;
      chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("row%0d ramWriteEnable", i), 32'(ramWriteEnable), 32'(vecs[i].rwe));
      chk($sformatf("row%0d ramWriteAddr", i), 32'(ramWriteAddr), 32'(vecs[i].addr));
      chk($sformatf("row%0d ramWriteData", i), 32'(ramWriteData), 32'(vecs[i].wdata));
      chk($sformatf("row%0d ramReadAddr", i), 32'(ramReadAddr), 32'(vecs[i].addr));
      chk($sformatf("row%0d rvalid", i), 32'(rvalid), 32'(vecs[i].rvalid));
      chk($sformatf("row%0d err", i), 32'(err), 32'(vecs[i].err));
      if (vecs[i].rvalid != 2'b00)
        chk($sformatf("row%0d rdata", i), 32'(rdata), 32'(vecs[i].rdata));
    end

    // Lock bound: AUX locked, CPU competing (last grant was CPU)
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(2'b11, 2'b00, 2'b10, 16'h0010, 16'h0020, 16'h0, 16'h0);
      #2;
      chk($sformatf("lockbound c%0d gnt", c), 32'(gnt), (c == 8) ? 32'h1 : 32'h2);
    end
    // Lock released while owned: tie follows round-robin (last grant AUX)
    @(negedge clk);
    drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0);
    #2;
    chk("lock release gnt", 32'(gnt), 32'h1);

    // Lock counter holds at zero while CPU is idle
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive(2'b10, 2'b00, 2'b10, 16'h0010, 16'h0020, 16'h0, 16'h0);
      #2;
      chk($sformatf("solo lock c%0d gnt", c), 32'(gnt), 32'h2);
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drive(2'b11, 2'b00, 2'b10, 16'h0010, 16'h0020, 16'h0, 16'h0);
      #2;
      chk($sformatf("late contend c%0d gnt", c), 32'(gnt), (c == 8) ? 32'h1 : 32'h2);
    end

    // Async reset between acceptance and rvalid
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0);
    #1 rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0);
    #2;
    chk("post-reset rvalid", 32'(rvalid), 32'h0);
    chk("post-reset err", 32'(err), 32'h0);
    chk("post-reset tie gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    #2;
    chk("post-reset read rvalid", 32'(rvalid), 32'h1);
    chk("post-reset read rdata", 32'(rdata), 32'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-write/single-read-port data RAM between two requesters: port 0 (CPU) and port 1 (AUX, a debug/loader or video-scan master).
- Sits between the requesters and the RAM instance. Clock is the same clock that drives the RAM.
- Performs one access per cycle, round-robin arbitration, optional bus lock with bounded hold, and range checking against NumRegs.

Parameters:
- DataWidth, 16, data word width.
- AddrWidth, 16, requester address width.
- NumRegs, 4096, populated RAM words; valid addresses are 0..NumRegs-1.
- MaxLock, 8, maximum consecutive grants to one locked port while the other port is requesting.

Ports:
- clk  in  1  clock; also clocks the RAM.
- rstN  in  1  asynchronous active-low reset.
- req[1:0]  in  2  access request per port (0=CPU, 1=AUX).
- we[1:0]  in  2  1=write, 0=read; sampled only with req.
- lock[1:0]  in  2  holds the grant for a multi-access sequence.
- addr0, addr1  in  AddrWidth  per-port word address.
- wdata0, wdata1  in  DataWidth  per-port write data.
- gnt[1:0]  out  2  combinational one-hot grant; req&gnt = access accepted this cycle.
- rvalid[1:0]  out  2  read data valid for that port, registered.
- rdata  out  DataWidth  read data, shared by both ports, qualified by rvalid.
- err[1:0]  out  2  one-cycle pulse: the accepted access was out of range.
- ramWriteEnable  out  1  to RAM.
- ramWriteAddr  out  AddrWidth  to RAM.
- ramWriteData  out  DataWidth  to RAM.
- ramReadAddr  out  AddrWidth  to RAM.
- ramReadData  in  DataWidth  from RAM; synchronous, 1-cycle latency.

Behaviour:
- Reset (async, rstN=0):
  - rvalid, err and lockCnt = 0; owner = NONE; lastGnt = 1, so CPU wins the first tie.
  - gnt is combinational and evaluates to 0 whenever req=0.
- States: IDLE, OWN0, OWN1.
  - IDLE: no port holds a lock.
  - OWNn: port n was granted with lock[n]=1.
- Grant rule, evaluated each cycle:
  - In IDLE, a single requester is granted. If both request, grant the port other than lastGnt.
  - In OWNn, port n is granted while req[n]&lock[n].
  - Leave OWNn to IDLE on the first cycle where req[n]=0 or lock[n]=0; arbitration in that cycle follows the IDLE rule.
- Lock bound:
  - lockCnt counts consecutive OWNn grants while the other port requests.
  - When lockCnt reaches MaxLock, the other port gets the next grant; the state becomes OWN(other) if its lock is set, otherwise IDLE; lockCnt clears.
  - lockCnt clears whenever the other port is not requesting.
- Accepted access:
  - RAM outputs are driven from the granted port's addr/wdata the same cycle.
  - ramWriteEnable = accepted & we & inRange.
  - ramReadAddr is always driven from the granted port's addr (0 when nothing is granted).
  - lastGnt updates to the granted port.
- Read:
  - rvalid[n] pulses 1 cycle after an accepted read by port n.
  - rdata = ramReadData, or 0 if the read was out of range.
  - Throughput is 1 read per cycle, back-to-back.
- Range: inRange = addr < NumRegs, compared at full AddrWidth with no wrap. Out-of-range writes are dropped; out-of-range reads return 0. err[n] pulses in the cycle after acceptance, aligned with rvalid for reads.
- Simultaneous events:
  - A write and a read to the same address cannot occur in one cycle: one port per cycle.
  - A read following a write to the same address gets the new data; this relies on the RAM read-after-write ordering across cycles.
- Reset mid-operation clears pending rvalid/err; no spurious pulse after rstN deasserts.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- When defined, adds outputs grantCnt0, grantCnt1 and conflictCnt, each 16 bits and saturating at 0xFFFF, plus input statsClr, a synchronous clear.
  - grantCntN counts accepted accesses by port N.
  - conflictCnt counts cycles where both ports request.
- When undefined, none of these ports or counters exist and the functional behaviour is identical.

Decomposition:
- Shared package ram_arb_pkg holds:
  - enum typedef arb_state_t {IDLE, OWN0, OWN1};
  - localparams PORT_CPU=0 and PORT_AUX=1;
  - typedef port_id_t.
- One natural sub-module: ram_arb_sat_counter, a 16-bit saturating counter with clear/enable, instantiated three times under RAM_ARB_STATS_EN.

Test Plan:
- CPU-only read: req=01, we=0, addr0=0x0010 with RAM[0x10]=0xBEEF -> gnt=01 same cycle; next cycle rvalid=01, rdata=0xBEEF.
- Tie after reset: both ports request reads every cycle, no lock -> grants alternate CPU, AUX, CPU, AUX; rvalid follows one cycle later.
- Lock bound: AUX lock=1 with continuous req, CPU requesting, MaxLock=8 -> AUX granted exactly 8 consecutive cycles, then CPU granted once, then AUX resumes.
- Out of range: NumRegs=4096, CPU writes 0x1234 to 0x1000 -> ramWriteEnable=0, err[0] pulses next cycle; a read of 0x1000 -> rdata=0, rvalid and err pulse together.
- Write then read: AUX writes 0x00AA to 0x0005, CPU reads 0x0005 the next cycle -> rdata=0x00AA.
- Async reset mid-read: rstN low between acceptance and the rvalid cycle -> rvalid stays 0; after release with both ports requesting, CPU is granted first.
